// File: rtl/niospherisys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: one quotient bit per clock,
// quotient and remainder delivered with a one-cycle done pulse 33 clocks after start.
module niospherisys_cpu_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  M_div_start,
  input  logic                  M_div_signed,
  input  logic [DATA_WIDTH-1:0] M_div_src1,
  input  logic [DATA_WIDTH-1:0] M_div_src2,
  input  logic                  M_div_kill,
  output logic                  M_div_busy,
  output logic                  M_div_done,
  output logic [DATA_WIDTH-1:0] M_div_quot,
  output logic [DATA_WIDTH-1:0] M_div_rem
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // CALC  | one restoring iteration per clock, DATA_WIDTH iterations
  // FIX   | apply result signs / divide-by-zero values, pulse done
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] dvd;
  logic [DATA_WIDTH:0]   prem;
  logic [DATA_WIDTH-1:0] dsr;
  logic [DATA_WIDTH-1:0] src1_q;
  logic                  neg_a;
  logic                  neg_b;
  logic                  div_zero;

  logic                  a_neg_in;
  logic                  b_neg_in;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] trial;
  logic [DATA_WIDTH-1:0] quot_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  // Partial remainder stays below the divisor, so the low DATA_WIDTH bits plus
  // the incoming dividend bit hold the whole shifted value; trial carries a sign bit.
  always_comb begin
    a_neg_in = M_div_signed & M_div_src1[DATA_WIDTH-1];
    b_neg_in = M_div_signed & M_div_src2[DATA_WIDTH-1];
    abs_a    = a_neg_in ? (~M_div_src1 + 1'b1) : M_div_src1;
    abs_b    = b_neg_in ? (~M_div_src2 + 1'b1) : M_div_src2;
    shifted  = {prem[DATA_WIDTH-1:0], dvd[DATA_WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dsr};
    quot_fix = (neg_a ^ neg_b) ? (~dvd + 1'b1) : dvd;
    rem_fix  = neg_a ? (~prem[DATA_WIDTH-1:0] + 1'b1) : prem[DATA_WIDTH-1:0];
    if (div_zero) begin
      quot_fix = '1;
      rem_fix  = src1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      dvd        <= '0;
      prem       <= '0;
      dsr        <= '0;
      src1_q     <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      div_zero   <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
    end else begin
      M_div_done <= 1'b0;
      if (M_div_kill) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (M_div_start) begin
              neg_a    <= a_neg_in;
              neg_b    <= b_neg_in;
              dvd      <= abs_a;
              dsr      <= abs_b;
              src1_q   <= M_div_src1;
              div_zero <= (M_div_src2 == '0);
              prem     <= '0;
              count    <= '0;
              state    <= CALC;
            end
          end
          CALC: begin
            if (!trial[DATA_WIDTH+1]) begin
              prem <= trial[DATA_WIDTH:0];
              dvd  <= {dvd[DATA_WIDTH-2:0], 1'b1};
            end else begin
              prem <= shifted;
              dvd  <= {dvd[DATA_WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST) state <= FIX;
          end
          FIX: begin
            M_div_quot <= quot_fix;
            M_div_rem  <= rem_fix;
            M_div_done <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign M_div_busy = (state != IDLE);

endmodule

// File: tb/tb_niospherisys_cpu_div_cell.sv
// Scoreboard bench for the iterative divider: stimulus pushes expected results,
// a monitor pops and compares them (value and latency) on every done pulse.
module tb_niospherisys_cpu_div_cell;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  niospherisys_cpu_div_cell #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .M_div_start  (start),
    .M_div_signed (sgn),
    .M_div_src1   (src1),
    .M_div_src2   (src2),
    .M_div_kill   (kill),
    .M_div_busy   (busy),
    .M_div_done   (done),
    .M_div_quot   (quot),
    .M_div_rem    (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_quot", e.id), quot, e.q);
        check($sformatf("op%0d_rem", e.id), rem, e.r);
        check($sformatf("op%0d_latency", e.id), cyc, e.cyc);
      end
    end
  end

  // Caller is at a negedge; the next posedge is the start edge E0, done seen 34 negedges on.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input int id, input bit push);
    exp_t e;
    sgn   = s;
    src1  = a;
    src2  = b;
    start = 1'b1;
    if (push) begin
      e.q = q; e.r = r; e.cyc = cyc + 34; e.id = id;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int id);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL op%0d_timeout: got no done in 60 cycles expected done", id);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int id);
    int nb;
    @(negedge clk);
    issue(s, a, b, q, r, id, 1'b1);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check($sformatf("op%0d_busy_cycles", id), nb, 33);
    wait_empty(id);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    sgn     = 1'b0;
    src1    = '0;
    src2    = '0;
    kill    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", quot, 32'd0);
    check("reset_rem", rem, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd100,       32'd7,       32'h0000000E, 32'h00000002, 1);
    run_op(1'b1, 32'hFFFFFFF9,  32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 2);
    run_op(1'b0, 32'hFFFFFFF9,  32'd2,       32'h7FFFFFFC, 32'h00000001, 3);
    run_op(1'b1, 32'h80000000,  32'hFFFFFFFF,32'h80000000, 32'h00000000, 4);
    run_op(1'b0, 32'hFFFFFFFF,  32'd1,       32'hFFFFFFFF, 32'h00000000, 5);
    run_op(1'b1, 32'd5,         32'd0,       32'hFFFFFFFF, 32'h00000005, 6);
    run_op(1'b0, 32'd5,         32'd0,       32'hFFFFFFFF, 32'h00000005, 7);

    // Start while busy is ignored; a start in the done cycle is accepted.
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 8, 1'b1);
    repeat (9) @(negedge clk);
    issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("op8_done_seen", {31'd0, done}, 32'd1);
    end
    issue(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 9, 1'b1);
    wait_empty(9);

    // Kill mid-CALC: no done, results held.
    @(negedge clk);
    issue(1'b0, 32'd77, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    repeat (14) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_drop", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_quot_held", quot, 32'hFFFFFFF2);
    check("kill_rem_held", rem, 32'h00000002);

    // Kill together with start in IDLE: start ignored.
    sgn = 1'b0; src1 = 32'd50; src2 = 32'd5; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-CALC.
    issue(1'b0, 32'd200, 32'd9, 32'd0, 32'd0, 0, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_quot", quot, 32'd0);
    check("rst_mid_rem", rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_release_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/niospherisys_cpu_div_cell.md
Name: niospherisys_cpu_div_cell

Overview:
Iterative 32-bit integer divider for the Nios II CPU M-stage. It is the inverse companion of the CPU multiply cell and serves div/divu instructions. It accepts a dividend/divisor pair on a start pulse and runs a radix-2 restoring algorithm, one bit per clock. It returns quotient and remainder with a one-cycle done pulse at a fixed latency. A pipeline kill input aborts an operation in flight.

Parameters:
DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
M_div_start  input  1  start request; sampled only in IDLE
M_div_signed  input  1  1 = signed (div), 0 = unsigned (divu); captured with start
M_div_src1  input  32  dividend; captured with start
M_div_src2  input  32  divisor; captured with start
M_div_kill  input  1  abort current operation (pipeline flush)
M_div_busy  output  1  high whenever state != IDLE
M_div_done  output  1  single-cycle completion pulse
M_div_quot  output  32  quotient; held until next completion
M_div_rem  output  32  remainder; held until next completion

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, quot=0, rem=0, counter=0, internal regs=0. Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - capture the sign flags: dividend negative = signed & src1[31], divisor negative = signed & src2[31].
  - capture |src1| and |src2| (two's complement negate when the flag is set), original src1, and a zero-divisor flag (src2==0).
  - clear partial remainder and counter; go to CALC.
- CALC, edges E1..E32 (one iteration per edge):
  - shift {partial remainder, dividend} left by 1.
  - trial = remainder_hi − |divisor|.
  - if trial is non-negative, remainder_hi=trial and shift in quotient bit 1; else shift in 0.
  - counter increments; at counter==DATA_WIDTH−1 go to FIX.
- FIX, edge E33:
  - quot = negated raw quotient if the two sign flags differ, else raw quotient.
  - rem = negated raw remainder if the dividend sign flag is set, else raw remainder.
  - register quot/rem, done=1, go to IDLE.
- Latency: done is high in the cycle after E33, exactly 33 clocks after the start edge. busy is high from after E0 through the cycle ending at E33. done deasserts at E34.
- Back-to-back: a start in the cycle that done is high is sampled at E34 and accepted (state is already IDLE). Throughput is one division per 34 cycles.
- Start while busy: ignored. Captured operands are unchanged and no queueing occurs.
- Kill: kill=1 at any edge in CALC or FIX forces state=IDLE with no done pulse and quot/rem unchanged.
  - Kill has priority over FIX completion.
  - Kill in IDLE together with start: kill wins and start is ignored.
- Divide by zero (flag set): full latency is preserved. In FIX, quot=0xFFFFFFFF and rem=original src1, regardless of signed mode.
- Signed overflow (src1=0x80000000, src2=0xFFFFFFFF, signed): quot=0x80000000, rem=0. This falls out of the 32-bit wrap of negation; no special case is needed, but it must be verified.
- Width rules:
  - the partial remainder is DATA_WIDTH+1 bits so the trial subtract carries a sign.
  - |0x80000000| is treated as unsigned 0x80000000.
  - all negation is modulo 2^DATA_WIDTH.
- Results follow truncating division (quotient rounds toward zero); the remainder takes the sign of the dividend.

Test Plan:
- Unsigned 100/7 (signed=0): start at E0 -> done exactly at E33+, quot=0x0000000E, rem=0x00000002, busy high 33 cycles.
- Signed −7/2 (src1=0xFFFFFFF9, src2=0x00000002, signed=1) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; same data unsigned -> quot=0x7FFFFFFC, rem=0x00000001.
- Signed overflow 0x80000000/0xFFFFFFFF, signed=1 -> quot=0x80000000, rem=0x00000000; unsigned 0xFFFFFFFF/0x00000001 -> quot=0xFFFFFFFF, rem=0.
- Divide by zero 5/0, signed and unsigned -> done at same latency, quot=0xFFFFFFFF, rem=0x00000005.
- Start pulsed at cycle 10 of a busy op with different operands -> ignored, first result intact. A new start in the done cycle is accepted and completes 33 cycles later.
- Kill at cycle 15 of CALC -> busy drops next cycle, no done, quot/rem keep previous values. reset_n low mid-CALC -> all outputs 0 immediately, no done after release.
